// File: rtl/keystat_animator.sv
// keystat_animator
//   Avalon-MM master that animates the 51 keystat bytes of the canvas register
//   file. Every STEP_FRAMES video frames it sweeps all keystats with a
//   read-modify-write: entering notes grow and glows fade. Between sweep
//   accesses it also writes judgement/touch events from game logic straight
//   into the target keystat.
//
// Ports
//   clk_i          system clock, shared with the canvas slave
//   rst_ni         asynchronous active-low reset
//   vs_i           VGA vertical sync (active low, asynchronous to clk_i)
//   enable_i       1 = frame divider runs; 0 = divider holds (events still served)
//   evt_valid_i    event request
//   evt_ready_o    event accepted on a cycle with evt_valid_i && evt_ready_o
//   evt_key_i      target key index 0..NKEYS-1
//   evt_type_i     0 touch, 1 spawn, 2 lost, 3 far, 4 pure, 5-7 reserved
//   evt_drop_o     one-cycle pulse after an accepted event with bad key/type
//   avm_cs_o       Avalon chip select
//   avm_rden_o     Avalon read strobe
//   avm_wren_o     Avalon write strobe
//   avm_addr_o     Avalon address (holds when idle)
//   avm_wdata_o    Avalon write data (holds when idle)
//   avm_rdata_i    Avalon read data, valid the cycle after avm_rden_o
//   busy_o         sweep in progress
//   sweep_done_o   one-cycle pulse when a sweep finishes
module keystat_animator #(
    parameter int unsigned STEP_FRAMES = 4,
    parameter int unsigned NKEYS       = 51,
    parameter logic [5:0]  KEY_BASE    = 6'h05
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       vs_i,
    input  logic       enable_i,
    input  logic       evt_valid_i,
    output logic       evt_ready_o,
    input  logic [5:0] evt_key_i,
    input  logic [2:0] evt_type_i,
    output logic       evt_drop_o,
    output logic       avm_cs_o,
    output logic       avm_rden_o,
    output logic       avm_wren_o,
    output logic [5:0] avm_addr_o,
    output logic [7:0] avm_wdata_o,
    input  logic [7:0] avm_rdata_i,
    output logic       busy_o,
    output logic       sweep_done_o
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StEvtWr = 3'd1;
    localparam logic [2:0] StRd    = 3'd2;
    localparam logic [2:0] StCap   = 3'd3;
    localparam logic [2:0] StWr    = 3'd4;
    localparam logic [2:0] StNext  = 3'd5;

    localparam logic [7:0] LastFrame = 8'(STEP_FRAMES - 1);
    localparam logic [5:0] LastKey   = 6'(NKEYS - 1);

    logic [2:0] state_q, state_d;
    logic [5:0] key_q, key_d;
    logic       busy_q, busy_d;
    logic       ret_rd_q, ret_rd_d;   // resume the sweep (RD) after an event write
    logic       ready_q, ready_d;
    logic       drop_q, drop_d;
    logic       done_q, done_d;
    logic       cs_q, cs_d;
    logic       rden_q, rden_d;
    logic       wren_q, wren_d;
    logic [5:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;

    logic       vs_q1, vs_q2, vs_q3;
    logic [7:0] frame_q, frame_d;
    logic       pend_q, pend_d;
    logic       pend_clr;
    logic       frame_tick;

    logic       evt_ok;
    logic       evt_accept;
    logic [7:0] evt_data;
    logic [7:0] cap_v;
    logic [7:0] cap_new;
    logic       cap_wr;
    logic [2:0] next_ctx;

    // vs_q3 only serves edge detection on the synchronized signal.
    assign frame_tick = vs_q3 & ~vs_q2;

    always_comb begin
        frame_d = frame_q;
        pend_d  = pend_q & ~pend_clr;
        if (enable_i && frame_tick) begin
            if (frame_q >= LastFrame) begin
                frame_d = 8'd0;
                pend_d  = 1'b1;
            end else begin
                frame_d = frame_q + 8'd1;
            end
        end
    end

    assign evt_ok     = (evt_key_i <= LastKey) && (evt_type_i <= 3'd4);
    assign evt_accept = evt_valid_i && ready_q;

    always_comb begin
        case (evt_type_i)
            3'd0:    evt_data = 8'hE0;
            3'd1:    evt_data = 8'hE1;
            3'd2:    evt_data = {3'd7, 2'd1, 3'd7};
            3'd3:    evt_data = {3'd7, 2'd2, 3'd7};
            3'd4:    evt_data = {3'd7, 2'd3, 3'd7};
            default: evt_data = 8'h00;
        endcase
    end

    // Keystat animation rule: {BRGHT[7:5], COLOR[4:3], NSIZE[2:0]}.
    assign cap_v = avm_rdata_i;
    always_comb begin
        cap_new = 8'h00;
        cap_wr  = 1'b0;
        if (cap_v == 8'h00) begin
            cap_wr = 1'b0;
        end else if (cap_v[4:3] == 2'd0 && cap_v[2:0] != 3'd0 && cap_v[2:0] != 3'd7) begin
            cap_new = {cap_v[7:3], cap_v[2:0] + 3'd1};
            cap_wr  = 1'b1;
        end else if (cap_v[4:3] == 2'd0 && cap_v[2:0] == 3'd7) begin
            cap_wr = 1'b0;   // full-size note waits for its judgement
        end else if (cap_v[7:5] > 3'd1) begin
            cap_new = {cap_v[7:5] - 3'd1, cap_v[4:0]};
            cap_wr  = 1'b1;
        end else begin
            cap_new = 8'h00;
            cap_wr  = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        busy_d   = busy_q;
        ret_rd_d = ret_rd_q;
        drop_d   = 1'b0;
        done_d   = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        pend_clr = 1'b0;
        next_ctx = StIdle;

        case (state_q)
            StIdle: begin
                if (evt_valid_i) begin
                    if (ready_q) begin
                        ret_rd_d = 1'b0;
                        if (evt_ok) begin
                            state_d = StEvtWr;
                            addr_d  = KEY_BASE + evt_key_i;
                            wdata_d = evt_data;
                        end else begin
                            drop_d = 1'b1;
                        end
                    end
                end else if (pend_q) begin
                    pend_clr = 1'b1;
                    key_d    = 6'd0;
                    busy_d   = 1'b1;
                    state_d  = StRd;
                end
            end
            StRd:  state_d = StCap;
            StCap: begin
                if (cap_wr) begin
                    state_d = StWr;
                    wdata_d = cap_new;
                end else begin
                    state_d = StNext;
                end
            end
            StWr:  state_d = StNext;
            StNext: begin
                if (key_q == LastKey) begin
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    ret_rd_d = 1'b0;
                    next_ctx = StIdle;
                end else begin
                    key_d    = key_q + 6'd1;
                    ret_rd_d = 1'b1;
                    next_ctx = StRd;
                end
                state_d = next_ctx;
                if (evt_accept) begin
                    if (evt_ok) begin
                        state_d = StEvtWr;
                        addr_d  = KEY_BASE + evt_key_i;
                        wdata_d = evt_data;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            StEvtWr: state_d = ret_rd_q ? StRd : StIdle;
            default: state_d = StIdle;
        endcase

        // Bus strobes are registered from the next state so they line up
        // with the state that owns them.
        if (state_d == StRd || state_d == StWr) begin
            addr_d = KEY_BASE + key_d;
        end
        cs_d    = (state_d == StRd) || (state_d == StWr) || (state_d == StEvtWr);
        rden_d  = (state_d == StRd);
        wren_d  = (state_d == StWr) || (state_d == StEvtWr);
        ready_d = (state_d == StIdle) || (state_d == StNext);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vs_q1    <= 1'b1;
            vs_q2    <= 1'b1;
            vs_q3    <= 1'b1;
            frame_q  <= 8'd0;
            pend_q   <= 1'b0;
            state_q  <= StIdle;
            key_q    <= 6'd0;
            busy_q   <= 1'b0;
            ret_rd_q <= 1'b0;
            ready_q  <= 1'b0;
            drop_q   <= 1'b0;
            done_q   <= 1'b0;
            cs_q     <= 1'b0;
            rden_q   <= 1'b0;
            wren_q   <= 1'b0;
            addr_q   <= 6'd0;
            wdata_q  <= 8'd0;
        end else begin
            vs_q1    <= vs_i;
            vs_q2    <= vs_q1;
            vs_q3    <= vs_q2;
            frame_q  <= frame_d;
            pend_q   <= pend_d;
            state_q  <= state_d;
            key_q    <= key_d;
            busy_q   <= busy_d;
            ret_rd_q <= ret_rd_d;
            ready_q  <= ready_d;
            drop_q   <= drop_d;
            done_q   <= done_d;
            cs_q     <= cs_d;
            rden_q   <= rden_d;
            wren_q   <= wren_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign evt_ready_o  = ready_q;
    assign evt_drop_o   = drop_q;
    assign avm_cs_o     = cs_q;
    assign avm_rden_o   = rden_q;
    assign avm_wren_o   = wren_q;
    assign avm_addr_o   = addr_q;
    assign avm_wdata_o  = wdata_q;
    assign busy_o       = busy_q;
    assign sweep_done_o = done_q;

endmodule

// File: tb/tb_keystat_animator.sv
// Testbench for keystat_animator: canvas slave model, bus log, and a
// rule-level reference model of the keystat animation.
module tb_keystat_animator;

    localparam logic [5:0] Base = 6'h05;
    localparam int         NK   = 51;

    typedef struct packed {
        logic       wr;
        logic [5:0] a;
        logic [7:0] d;
    } xact_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vs;
    logic       enable;
    logic       evt_valid;
    logic       evt_ready;
    logic [5:0] evt_key;
    logic [2:0] evt_type;
    logic       evt_drop;
    logic       cs, rden, wren;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy, done;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [0:63];
    logic [7:0] expm [0:NK-1];
    int         exp_wr;
    xact_t      log_q[$];
    int         drop_cnt = 0;
    int         done_cnt = 0;
    int         busy_viol = 0;

    always #5 clk = ~clk;

    keystat_animator dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .vs_i        (vs),
        .enable_i    (enable),
        .evt_valid_i (evt_valid),
        .evt_ready_o (evt_ready),
        .evt_key_i   (evt_key),
        .evt_type_i  (evt_type),
        .evt_drop_o  (evt_drop),
        .avm_cs_o    (cs),
        .avm_rden_o  (rden),
        .avm_wren_o  (wren),
        .avm_addr_o  (addr),
        .avm_wdata_o (wdata),
        .avm_rdata_i (rdata),
        .busy_o      (busy),
        .sweep_done_o(done)
    );

    // Canvas slave: 1-cycle registered read, immediate write.
    always @(posedge clk) begin
        if (cs && rden) begin
            rdata <= mem[addr];
            log_q.push_back('{wr: 1'b0, a: addr, d: 8'h00});
        end
        if (cs && wren) begin
            mem[addr] = wdata;
            log_q.push_back('{wr: 1'b1, a: addr, d: wdata});
        end
        if (evt_drop) drop_cnt++;
        if (done) done_cnt++;
        if (rden && !busy) busy_viol++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference rule: returns {write_needed, new_value}.
    function automatic logic [8:0] ref_anim(input logic [7:0] v);
        int b, c, n;
        b = int'(v) / 32;
        c = (int'(v) / 8) % 4;
        n = int'(v) % 8;
        if (v == 8'h00) return 9'h000;
        if (c == 0 && n >= 1 && n <= 6) return {1'b1, v + 8'd1};
        if (c == 0 && n == 7) return 9'h000;
        if (b > 1) return {1'b1, v - 8'd32};
        return {1'b1, 8'h00};
    endfunction

    function automatic logic [7:0] ev_data(input int t);
        case (t)
            0: return 8'hE0;
            1: return 8'hE1;
            2: return 8'hEF;
            3: return 8'hF7;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic model_load();
        for (int k = 0; k < NK; k++) expm[k] = mem[k + 5];
        exp_wr = 0;
    endtask

    task automatic model_range(input int lo, input int hi);
        logic [8:0] r;
        for (int k = lo; k <= hi; k++) begin
            r = ref_anim(expm[k]);
            if (r[8]) begin
                expm[k] = r[7:0];
                exp_wr++;
            end
        end
    endtask

    task automatic compare_mem(input string tag);
        int bad = 0;
        for (int k = 0; k < NK; k++) if (mem[k + 5] !== expm[k]) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic frame_edge();
        vs = 1'b0;
        repeat (4) @(posedge clk);
        vs = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic wait_done(input string tag);
        int base = done_cnt;
        int n = 0;
        while (done_cnt == base && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, (done_cnt != base), 1);
        repeat (3) @(negedge clk);
    endtask

    function automatic int count_writes(input int l0);
        int w = 0;
        for (int i = l0; i < log_q.size(); i++) if (log_q[i].wr) w++;
        return w;
    endfunction

    task automatic check_reads(input int l0, input string tag);
        int nr = 0;
        int bad = 0;
        for (int i = l0; i < log_q.size(); i++) begin
            if (!log_q[i].wr) begin
                if (log_q[i].a !== 6'(5 + nr)) bad++;
                nr++;
            end
        end
        chk({tag, "_nreads"}, nr, NK);
        chk({tag, "_read_order"}, bad, 0);
    endtask

    task automatic send_evt(input logic [5:0] k, input logic [2:0] t);
        int n = 0;
        @(negedge clk);
        evt_valid = 1'b1;
        evt_key   = k;
        evt_type  = t;
        while (!evt_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("evt_ready_at_accept", evt_ready, 1'b1);
        @(posedge clk);
        #1;
        evt_valid = 1'b0;
    endtask

    initial begin
        int l0, d0, ek, et, r, n;
        xact_t e1, e2, e3;

        rst_n = 1'b0; vs = 1'b1; enable = 1'b1;
        evt_valid = 1'b0; evt_key = 6'd0; evt_type = 3'd0;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        #2;
        chk("reset_outputs", {evt_ready, evt_drop, cs, rden, wren, addr, wdata, busy, done}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", evt_ready, 1'b1);

        // Idle sweep: 3 frames quiet, 4th starts a read-only sweep.
        l0 = log_q.size(); d0 = done_cnt;
        repeat (3) frame_edge();
        repeat (10) @(negedge clk);
        chk("t1_quiet_3_frames", log_q.size(), l0);
        frame_edge();
        wait_done("t1");
        check_reads(l0, "t1");
        chk("t1_writes", count_writes(l0), 0);
        chk("t1_done_pulses", done_cnt - d0, 1);
        chk("t1_busy_during_reads", busy_viol, 0);
        chk("t1_busy_after", busy, 1'b0);

        // Grow/fade: fixed first five keys, random remainder, two sweeps.
        for (int i = 0; i < NK; i++) mem[i + 5] = 8'($urandom_range(0, 255));
        mem[5] = 8'h01; mem[6] = 8'h07; mem[7] = 8'hE0; mem[8] = 8'h3B; mem[9] = 8'h00;
        for (int rep = 0; rep < 2; rep++) begin
            model_load();
            model_range(0, NK - 1);
            l0 = log_q.size();
            repeat (4) frame_edge();
            wait_done("t2");
            check_reads(l0, "t2");
            chk("t2_write_count", count_writes(l0), exp_wr);
            compare_mem("t2_mem");
            if (rep == 0) begin
                chk("t2_key0", mem[5], 8'h02);
                chk("t2_key1", mem[6], 8'h07);
                chk("t2_key2", mem[7], 8'hC0);
                chk("t2_key3", mem[8], 8'h00);
                chk("t2_key4", mem[9], 8'h00);
            end
        end

        // Event while idle: pure on key 10.
        l0 = log_q.size();
        send_evt(6'd10, 3'd4);
        @(negedge clk);
        chk("t3_evt_strobes", {cs, rden, wren}, 3'b101);
        chk("t3_evt_addr", addr, 6'h0F);
        chk("t3_evt_wdata", wdata, 8'hFF);
        repeat (4) @(negedge clk);
        chk("t3_one_write", log_q.size() - l0, 1);
        chk("t3_mem", mem[6'h0F], 8'hFF);

        // Event raised while key 20 is in CAP.
        for (int i = 0; i < NK; i++) mem[i + 5] = 8'($urandom_range(0, 255));
        mem[5 + 20] = 8'h01;
        ek = $urandom_range(0, NK - 1);
        et = $urandom_range(0, 4);
        model_load();
        model_range(0, 20);
        expm[ek] = ev_data(et);
        model_range(21, NK - 1);
        l0 = log_q.size();
        repeat (4) frame_edge();
        n = 0;
        while (!(rden && addr == 6'h19) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t4_key20_rd_seen", (n < 500), 1);
        send_evt(6'(ek), 3'(et));
        wait_done("t4");
        check_reads(l0, "t4");
        r = -1;
        for (int i = l0; i < log_q.size(); i++)
            if (r < 0 && !log_q[i].wr && log_q[i].a == 6'h19) r = i;
        e1 = '0; e2 = '0; e3 = '0;
        if (r >= 0 && r + 3 < log_q.size()) begin
            e1 = log_q[r + 1]; e2 = log_q[r + 2]; e3 = log_q[r + 3];
        end
        chk("t4_key20_wr", e1, {1'b1, 6'h19, 8'h02});
        chk("t4_evt_wr", e2, {1'b1, 6'(5 + ek), ev_data(et)});
        chk("t4_key21_rd", e3, {1'b0, 6'h1A, 8'h00});
        compare_mem("t4_mem");

        // Invalid events are dropped without bus traffic.
        l0 = log_q.size(); d0 = drop_cnt;
        send_evt(6'd51, 3'd0);
        send_evt(6'd3, 3'd6);
        repeat (5) @(negedge clk);
        chk("t5_drops", drop_cnt - d0, 2);
        chk("t5_no_bus", log_q.size(), l0);

        // Async reset during a write.
        mem[5 + 10] = 8'h01;
        repeat (4) frame_edge();
        n = 0;
        while (!(wren && addr == 6'h0F) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t6_wr_seen", (n < 500), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_reset_outputs", {evt_ready, evt_drop, cs, rden, wren, addr, wdata, busy, done}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        l0 = log_q.size();
        repeat (3) frame_edge();
        repeat (10) @(negedge clk);
        chk("t6_quiet_after_reset", log_q.size(), l0);
        frame_edge();
        wait_done("t6");
        check_reads(l0, "t6");

        // Divider holds while disabled.
        enable = 1'b0;
        l0 = log_q.size();
        repeat (5) frame_edge();
        repeat (10) @(negedge clk);
        chk("t7_disabled_quiet", log_q.size(), l0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
